// File: rtl/instr_decoder.sv
// instr_decoder: decode/issue stage turning 9-bit instructions into ALU micro-ops, expanding ROL n into n beats
package Definitions;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] XOR = 3'b011;
  localparam logic [2:0] ROL = 3'b100;
  localparam logic [2:0] MOV = 3'b111;
endpackage

module instr_decoder #(
  parameter int IW  = 9,
  parameter int RAW = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           InstrValid,
  output logic           InstrReady,
  input  logic [IW-1:0]  Instr,
  output logic           IssueValid,
  input  logic           IssueReady,
  output logic [2:0]     IssueOp,
  output logic [RAW-1:0] IssueRd,
  output logic [RAW-1:0] IssueRs,
  output logic           IssueLast,
  output logic           IllegalOp,
  output logic           Busy
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t         state_q, state_d;
  logic [2:0]     rem_q, rem_d, op_q, op_d, opc;
  logic [RAW-1:0] rd_q, rd_d, rs_q, rs_d;
  logic           ill_q, ill_d, is_rol, is_alu, accept, load, beat;
  // state register: issue slot, remaining-beat counter and illegal pulse
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      rem_q   <= 3'd0;
      op_q    <= 3'd0;
      rd_q    <= '0;
      rs_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      ill_q   <= ill_d;
    end
  end
  // next state: a legal accept reloads the slot (even on the last beat), otherwise beats count down
  always_comb begin
    opc     = Instr[8:6];
    is_rol  = opc == Definitions::ROL;
    is_alu  = opc == Definitions::AND || opc == Definitions::XOR || opc == Definitions::MOV;
    accept  = InstrValid && InstrReady;
    load    = accept && (is_alu || (is_rol && Instr[2:0] != 3'd0));
    beat    = state_q == ISSUE && IssueReady;
    state_d = load ? ISSUE : (beat && rem_q == 3'd1) ? IDLE : state_q;
    rem_d   = load ? (is_rol ? Instr[2:0] : 3'd1) : beat ? rem_q - 3'd1 : rem_q;
    op_d    = load ? opc : op_q;
    rd_d    = load ? RAW'(Instr[5:3]) : rd_q;
    rs_d    = load ? RAW'(is_rol ? Instr[5:3] : Instr[2:0]) : rs_q;
    ill_d   = accept && !is_alu && !is_rol;
  end
  // outputs: ready is combinational from IssueReady so the slot reloads without a bubble
  always_comb begin
    IssueValid = state_q == ISSUE;
    IssueLast  = IssueValid && rem_q == 3'd1;
    InstrReady = !IssueValid || (IssueReady && rem_q == 3'd1);
    Busy       = IssueValid;
    IssueOp    = op_q;
    IssueRd    = rd_q;
    IssueRs    = rs_q;
    IllegalOp  = ill_q;
  end
endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: directed and random stimulus against a beat-queue reference model
module tb_instr_decoder;
  logic       Clk = 1'b0, Reset = 1'b0, InstrValid = 1'b0, IssueReady = 1'b0;
  logic [8:0] Instr = '0;
  logic       InstrReady, IssueValid, IssueLast, IllegalOp, Busy;
  logic [2:0] IssueOp, IssueRd, IssueRs;
  typedef struct {logic [2:0] op; logic [2:0] rd; logic [2:0] rs; logic last;} beat_t;
  beat_t q[$];
  logic  exp_ill = 1'b0;
  int    n_tests = 0, n_fail = 0;

  instr_decoder #(.IW(9), .RAW(3)) dut (
    .Clk(Clk), .Reset(Reset), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .IssueValid(IssueValid), .IssueReady(IssueReady),
    .IssueOp(IssueOp), .IssueRd(IssueRd), .IssueRs(IssueRs),
    .IssueLast(IssueLast), .IllegalOp(IllegalOp), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [8:0] in);
    beat_t b;
    int    n;
    case (in[8:6])
      3'b010, 3'b011, 3'b111: begin
        b = '{in[8:6], in[5:3], in[2:0], 1'b1};
        q.push_back(b);
      end
      3'b100: begin
        n = int'(in[2:0]);
        for (int i = 0; i < n; i++) begin
          b = '{3'b100, in[5:3], in[5:3], i == n - 1};
          q.push_back(b);
        end
      end
      default: exp_ill = 1'b1;
    endcase
  endtask

  // one clock: drive at negedge, check outputs, then advance the model on the edge
  task automatic cycle(input logic iv, input logic [8:0] in, input logic ir);
    logic rdy, acc;
    InstrValid = iv;
    Instr      = in;
    IssueReady = ir;
    #1;
    rdy = q.size() == 0 || (ir && q[0].last);
    chk("issue_valid", IssueValid, q.size() != 0);
    chk("busy", Busy, q.size() != 0);
    chk("instr_ready", InstrReady, rdy);
    chk("illegal", IllegalOp, exp_ill);
    if (q.size() != 0) begin
      chk("op", IssueOp, q[0].op);
      chk("rd", IssueRd, q[0].rd);
      chk("rs", IssueRs, q[0].rs);
      chk("last", IssueLast, q[0].last);
    end else chk("last_idle", IssueLast, 0);
    acc = iv && rdy;
    @(posedge Clk);
    if (q.size() != 0 && ir) void'(q.pop_front());
    exp_ill = 1'b0;
    if (acc) model_accept(in);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    InstrValid = 1'b1;
    Instr      = 9'b010_001_010;
    IssueReady = 1'b1;
    #2 Reset = 1'b0;
    #1;
    chk("rst_valid", IssueValid, 0);
    chk("rst_op", IssueOp, 0);
    chk("rst_rd", IssueRd, 0);
    chk("rst_rs", IssueRs, 0);
    chk("rst_last", IssueLast, 0);
    chk("rst_ill", IllegalOp, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_ready", InstrReady, 1);
    q.delete();
    exp_ill = 1'b0;
    @(negedge Clk);
    Reset      = 1'b1;
    InstrValid = 1'b0;
  endtask

  initial begin
    @(negedge Clk);
    do_reset();
    cycle(1, 9'b010_001_010, 1);
    cycle(0, 9'd0, 1);
    chk("and_op", IssueOp, 3'b010);
    cycle(1, 9'b011_010_011, 1);
    cycle(1, 9'b111_100_101, 1);
    cycle(1, 9'b010_110_111, 1);
    cycle(0, 9'd0, 1);
    cycle(1, 9'b100_101_011, 1);
    cycle(0, 9'd0, 1);
    cycle(0, 9'd0, 0);
    cycle(0, 9'd0, 1);
    cycle(0, 9'd0, 1);
    cycle(1, 9'b100_100_000, 1);
    cycle(1, 9'b101_000_000, 1);
    cycle(0, 9'd0, 1);
    cycle(0, 9'd0, 1);
    cycle(1, 9'b100_010_111, 1);
    cycle(0, 9'd0, 1);
    cycle(0, 9'd0, 1);
    do_reset();
    cycle(1, 9'b111_011_001, 1);
    cycle(0, 9'd0, 1);
    cycle(1, 9'b100_001_010, 1);
    cycle(1, 9'b111_110_010, 1);
    cycle(1, 9'b111_110_010, 1);
    cycle(0, 9'd0, 1);
    chk("reload_op", IssueOp, 3'b111);
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 9) < 7, 9'($urandom), $urandom_range(0, 9) < 6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_decoder.md
# instr_decoder

Front-end decode/issue stage between instruction fetch and the ALU. Accepts 9-bit instructions over a valid/ready handshake and issues one ALU micro-op per handshake beat, using the `Definitions::op_mne` encodings (AND, XOR, ROL, MOV). ROL with a rotate count of n is expanded into n single-bit ROL beats. Illegal opcodes are consumed and flagged, and nothing is issued for them.

## Interface
- `IW`, 9: instruction width, fixed at 9; other values are unsupported.
- `RAW`, 3: register address width.
- `Clk`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `InstrValid`  in  1  fetch presents `Instr`.
- `InstrReady`  out  1  decoder accepts `Instr` this cycle.
- `Instr`  in  IW  `[8:6]` opcode, `[5:3]` rd, `[2:0]` rs or rotate count.
- `IssueValid`  out  1  micro-op presented to the ALU.
- `IssueReady`  in  1  ALU accepts the micro-op.
- `IssueOp`  out  3  `op_mne` value.
- `IssueRd`  out  RAW  destination register.
- `IssueRs`  out  RAW  source register.
- `IssueLast`  out  1  final beat of the current instruction.
- `IllegalOp`  out  1  one-cycle pulse when an illegal opcode is consumed.
- `Busy`  out  1  an instruction is pending or in expansion.

## Operation
- Opcode decode:
  - 010 AND and 011 XOR: 1 beat, rd = `Instr[5:3]`, rs = `Instr[2:0]`.
  - 111 MOV: 1 beat, rd = `Instr[5:3]`, rs = `Instr[2:0]`.
  - 100 ROL: rotate count n = `Instr[2:0]`. Issues n beats, each with `IssueOp`=ROL, rd = rs = `Instr[5:3]`.
  - ROL with n=0: consumed as a NOP. Nothing is issued and `IllegalOp` stays 0.
  - 000, 001, 101, 110: illegal. Consumed, nothing issued, `IllegalOp` pulses.
- Handshakes:
  - A beat transfers on `IssueValid && IssueReady`.
  - An instruction transfers on `InstrValid && InstrReady`.
- Internal state:
  - Output register holding op, rd, and rs.
  - 3-bit remaining-beat counter `rem` (valid range 0..7).
- States:
  - IDLE: `rem`=0 and `IssueValid`=0.
  - ISSUE: `IssueValid`=1 and `rem`≥1.
- Transitions:
  - IDLE → ISSUE: a legal instruction with ≥1 beat is accepted.
  - ISSUE → ISSUE: a beat transfers with `rem`>1; `rem` decrements.
  - ISSUE → IDLE: the last beat transfers and no new legal instruction is accepted in the same cycle.
  - Last beat → ISSUE: the last beat transfers and a legal ≥1-beat instruction is accepted in the same cycle; state reloads without a bubble.
- Output rules:
  - `IssueLast` = (`rem`==1) while `IssueValid`.
  - `InstrReady` = !`IssueValid` || (`IssueReady` && `rem`==1). This is a combinational path from `IssueReady`, by design.
  - `Busy` = `IssueValid`.
- Outputs are held stable while `IssueValid && !IssueReady`.
- An illegal opcode or ROL-0 accepted in the same cycle as a last-beat transfer moves the block to IDLE.

## Timing
- Reset values:
  - `IssueValid`=0, `IssueOp`=000, `IssueRd`=0, `IssueRs`=0.
  - `IssueLast`=0, `IllegalOp`=0, `Busy`=0, `rem`=0.
  - `InstrReady`=1, because it is combinational from `IssueValid`.
- Reset is asynchronous. Assertion in mid-expansion immediately drops `IssueValid` and discards remaining beats; no partial instruction resumes.
- Latency: instruction accepted at edge k → first beat valid after edge k, i.e. cycle k+1.
- `IllegalOp` is high for exactly the cycle after the accepting edge.
- Throughput:
  - One beat per cycle with `IssueReady` held high.
  - Back-to-back 1-beat instructions sustain 1 instruction per cycle.
  - ROL n occupies ≥n cycles.
- No beat is dropped or duplicated under arbitrary `IssueReady` stalls.

## Test plan
- Reset: assert `Reset`=0 mid-cycle with `InstrValid`=1 → all outputs at their reset values asynchronously. Release, then present AND r1,r2 (`Instr`=9'b010_001_010) → next cycle `IssueOp`=010, `IssueRd`=1, `IssueRs`=2, `IssueLast`=1.
- Streaming: XOR, MOV, AND on consecutive cycles with `IssueReady`=1 → three beats on three consecutive cycles, `InstrReady` held at 1.
- ROL r5 by 3 (9'b100_101_011), `IssueReady` pattern 1,0,1,1 → exactly 3 ROL beats with rd = rs = 5. `IssueLast` is set only on the third beat. `InstrReady`=0 until the third beat transfers.
- ROL r4 by 0 (9'b100_100_000), then opcode 101 → no beats issued; `IllegalOp` pulses once, for the second instruction only.
- Reset mid-expansion: ROL r2 by 7, assert `Reset` after 2 beats → `IssueValid` drops immediately. After release, a MOV issues normally with `IssueLast`=1.
- Reload on last beat: MOV held on input while ROL by 2 finishes → MOV is valid in the cycle right after the second ROL beat, with no idle cycle.
